// File: rtl/booth_mul_pkg.sv
// Shared types and helpers for the sequential radix-4 Booth multiplier.
// Holds FSM state codes, the one-hot digit select type and the window decoder.
package booth_mul_pkg;

   localparam int unsigned DefaultWidth = 64;

   typedef logic [1:0] state_t;
   localparam state_t StIdle = 2'd0;
   localparam state_t StRun  = 2'd1;
   localparam state_t StDone = 2'd2;

   // One-hot select; all-zero means a zero digit.
   typedef struct packed {
      logic neg;
      logic pos;
      logic neg2;
      logic pos2;
   } booth_sel_t;

   function automatic booth_sel_t booth_decode(input logic [2:0] win);
      booth_sel_t sel;
      sel = '0;
      case (win)
         3'b001, 3'b010: sel.pos  = 1'b1;
         3'b011:         sel.pos2 = 1'b1;
         3'b100:         sel.neg2 = 1'b1;
         3'b101, 3'b110: sel.neg  = 1'b1;
         default:        sel      = '0;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/booth_seq_mul_ctrl_if.sv
// Issue/result handshake bundle for booth_seq_mul_ctrl.
// master = issue logic / result consumer, slave = the multiplier controller.
interface booth_seq_mul_ctrl_if
   import booth_mul_pkg::*;
#(
   parameter int unsigned WIDTH = DefaultWidth
);
   logic               in_valid;
   logic               in_ready;
   logic [WIDTH-1:0]   in_a;
   logic [WIDTH-1:0]   in_b;
   logic               abort;
   logic               out_valid;
   logic               out_ready;
   logic [2*WIDTH-1:0] out_p;
   logic               busy;

   modport master (
      output in_valid, in_a, in_b, abort, out_ready,
      input  in_ready, out_valid, out_p, busy
   );

   modport slave (
      input  in_valid, in_a, in_b, abort, out_ready,
      output in_ready, out_valid, out_p, busy
   );
endinterface

// File: rtl/booth_digit_row.sv
// Combinational radix-4 Booth row: decodes a 3-bit window and forms d*a at
// WIDTH+2 bits (d in -2..+2), wide enough that -2*min never overflows.
module booth_digit_row
   import booth_mul_pkg::*;
#(
   parameter int unsigned WIDTH = DefaultWidth
) (
   input  logic [2:0]       win_i,
   input  logic [WIDTH-1:0] a_i,
   output logic [WIDTH+1:0] row_o
);
   booth_sel_t       sel;
   logic [WIDTH+1:0] a1;
   logic [WIDTH+1:0] a2;

   assign sel = booth_decode(win_i);
   assign a1  = {{2{a_i[WIDTH-1]}}, a_i};
   assign a2  = {a_i[WIDTH-1], a_i, 1'b0};

   always_comb begin
      row_o = '0;
      unique case (1'b1)
         sel.pos:  row_o = a1;
         sel.neg:  row_o = -a1;
         sel.pos2: row_o = a2;
         sel.neg2: row_o = -a2;
         default:  row_o = '0;
      endcase
   end
endmodule

// File: rtl/booth_seq_mul_ctrl.sv
// Iterative signed radix-4 Booth multiplier: one partial-product row per clock.
// Define BOOTH_SEQ_EARLY_EXIT_EN to finish as soon as the remaining digits are zero.
module booth_seq_mul_ctrl
   import booth_mul_pkg::*;
#(
   parameter int unsigned WIDTH = DefaultWidth
) (
   input logic                clk,
   input logic                rst,
   booth_seq_mul_ctrl_if.slave bus
);
   localparam int unsigned ITER = WIDTH / 2;
   localparam int unsigned KW   = (ITER > 1) ? $clog2(ITER) : 1;

   state_t               state_q, state_d;
   logic [KW-1:0]        k_q, k_d;
   logic [WIDTH-1:0]     a_q, a_d;
   logic [WIDTH-1:0]     b_q, b_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic                 out_valid_q, out_valid_d;
   logic                 rdy_q;

   logic [KW:0]          shift2;
   logic [WIDTH:0]       b_sh;
   logic [2:0]           win;
   logic [WIDTH+1:0]     row;
   logic [2*WIDTH-1:0]   row_sh;
   logic                 finish;

   assign shift2 = {k_q, 1'b0};
   // b[-1] = 0 is the appended LSB.
   assign b_sh   = {b_q, 1'b0} >> shift2;
   assign win    = b_sh[2:0];

   booth_digit_row #(.WIDTH(WIDTH)) u_row (
      .win_i (win),
      .a_i   (a_q),
      .row_o (row)
   );

   assign row_sh = {{(WIDTH-2){row[WIDTH+1]}}, row} << shift2;

`ifdef BOOTH_SEQ_EARLY_EXIT_EN
   logic [WIDTH-1:0] b_hi;
   // Arithmetic shift leaves b[WIDTH-1:2k+1] sign-extended; uniform => rest are zero digits.
   assign b_hi   = $signed(b_q) >>> (shift2 + 1);
   assign finish = (k_q == KW'(ITER - 1)) || (b_hi == '0) || (b_hi == '1);
`else
   assign finish = (k_q == KW'(ITER - 1));
`endif

   always_comb begin
      state_d     = state_q;
      k_d         = k_q;
      a_d         = a_q;
      b_d         = b_q;
      acc_d       = acc_q;
      out_valid_d = out_valid_q;
      case (state_q)
         StIdle: begin
            if (rdy_q && bus.in_valid && !bus.abort) begin
               a_d     = bus.in_a;
               b_d     = bus.in_b;
               acc_d   = '0;
               k_d     = '0;
               state_d = StRun;
            end
         end
         StRun: begin
            if (bus.abort) begin
               k_d     = '0;
               state_d = StIdle;
            end else begin
               acc_d = acc_q + row_sh;
               if (finish) begin
                  k_d         = '0;
                  out_valid_d = 1'b1;
                  state_d     = StDone;
               end else begin
                  k_d = k_q + 1'b1;
               end
            end
         end
         StDone: begin
            if (bus.abort || bus.out_ready) begin
               out_valid_d = 1'b0;
               state_d     = StIdle;
            end
         end
         default: begin
            out_valid_d = 1'b0;
            k_d         = '0;
            state_d     = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         k_q         <= '0;
         a_q         <= '0;
         b_q         <= '0;
         acc_q       <= '0;
         out_valid_q <= 1'b0;
         rdy_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         k_q         <= k_d;
         a_q         <= a_d;
         b_q         <= b_d;
         acc_q       <= acc_d;
         out_valid_q <= out_valid_d;
         rdy_q       <= 1'b1;
      end
   end

   // rdy_q keeps in_ready low through reset without a path from rst.
   assign bus.in_ready  = rdy_q && (state_q == StIdle);
   assign bus.busy      = (state_q != StIdle);
   assign bus.out_valid = out_valid_q;
   assign bus.out_p     = acc_q;

endmodule

// File: doc/booth_seq_mul_ctrl.md
# booth_seq_mul_ctrl

Sequencer for an iterative signed radix-4 Booth multiplier. It accepts one operand pair over a valid/ready handshake and walks the multiplier through its Booth windows, one partial-product row per clock. Each row is added into a full-width accumulator, and the result is presented on a valid/ready output. It sits between the integer-execute issue logic and the result bus, and is the low-area alternative to the Wallace-tree multiplier.

## Interface
Parameters:
- WIDTH, 64, operand width; must be even and ≥ 4.
- ITER, WIDTH/2, number of Booth digits; derived, not overridable.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair offered.
- in_ready  out  1  controller can accept; high only in IDLE.
- in_a  in  WIDTH  multiplicand, two's complement.
- in_b  in  WIDTH  multiplier, two's complement.
- abort  in  1  discard current operation.
- out_valid  out  1  out_p holds a completed product.
- out_ready  in  1  consumer takes product.
- out_p  out  2*WIDTH  signed product in_a*in_b.
- busy  out  1  high in RUN or DONE.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && !abort: latch in_a and in_b, clear acc, set k=0, go to RUN.
- RUN:
  - Each cycle, digit k is decoded from window {b[2k+1], b[2k], b[2k-1]}, with b[-1]=0.
  - Decode: 000/111→0, 001/010→+1, 011→+2, 100→−2, 101/110→−1.
  - acc += sign_extend(d·a, 2*WIDTH) << 2k. d·a is formed at WIDTH+2 bits, then sign-extended; it is never truncated.
  - After adding digit ITER−1, go to DONE. Otherwise k++.
- DONE:
  - out_valid=1; out_p=acc, held stable.
  - On out_ready, go to IDLE.
- Arithmetic: accumulation is modulo 2^(2*WIDTH). The exact signed product always fits, including min×min = 2^(2*WIDTH−2).
- abort:
  - In RUN or DONE: go to IDLE on the next edge, with out_valid=0 and the result dropped.
  - In IDLE: abort overrides in_valid, and nothing is accepted.
- in_ready is 0 in RUN and DONE. in_valid presented then is ignored and must be held by the source.
- No overlap: a new operation is accepted only from IDLE.

## Timing
- Reset values: state=IDLE, out_valid=0, out_p=0, busy=0, k=0. in_ready=0 while rst is high and 1 on the first cycle after.
- Accept on edge E0. Rows are added on edges E1..E_ITER. out_valid is high from the cycle after E_ITER.
  - For the default configuration, the first possible consume is edge E33.
- Minimum issue interval is ITER+2 cycles, e.g. 34 at WIDTH=64.
- out_valid and out_p are registered. in_ready and busy are decoded from the state register only, with no combinational path from any input.
- Reset mid-operation behaves as abort and also zeroes out_p.

## Configuration
- Macro BOOTH_SEQ_EARLY_EXIT_EN.
- Defined:
  - After adding digit k in RUN, if in_b[WIDTH−1:2k+1] is all-0 or all-1, all remaining digits are zero, so go directly to DONE.
  - Latency becomes (digits consumed)+1 edges to out_valid.
- Undefined: a fixed ITER-cycle RUN regardless of operands, giving deterministic latency.
- Products are identical in both builds.

## Structure
- Package booth_mul_pkg holds:
  - the state enum (IDLE/RUN/DONE);
  - the Booth digit encoding (neg, pos, neg2, pos2 one-hot select type);
  - default WIDTH;
  - a helper function for the window-to-digit decode.
- One sub-module, booth_digit_row: combinational. It takes the 3-bit window and WIDTH-bit multiplicand and produces the WIDTH+2-bit signed row.
- The controller instantiates it once and owns the FSM, k counter, operand registers and accumulator.

## Test plan
- a=3, b=5 → out_p=15; out_valid first high exactly 33 edges after acceptance (fixed-latency build).
- a=−1, b=−1 → out_p=1. Separately, a=0x8000_0000_0000_0000, b=0x8000_0000_0000_0000 → out_p=0x4000_0000_0000_0000_0000_0000_0000_0000.
- a=0x7FFF_FFFF_FFFF_FFFF, b=−2 → out_p=0xFFFF_FFFF_FFFF_FFFF_0000_0000_0000_0002.
- Backpressure: hold out_ready=0 for 10 cycles in DONE with in_valid=1 → out_p stable and in_ready=0 throughout. On release, the product is consumed, IDLE follows, and the next pair is accepted the cycle after.
- abort asserted in RUN cycle 10 → IDLE next edge with out_valid never high. A following 6×7 yields 42. abort together with in_valid in IDLE → no acceptance.
- With BOOTH_SEQ_EARLY_EXIT_EN: a=9, b=1 → out_p=9 with out_valid high after E1. b=−3 → RUN of 2 cycles, out_p=−27.
